display_scan_ctrl: RTL and testbench

DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

---
 rtl/display_scan_ctrl.sv | 73 +++++++
 tb/tb_display_scan_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: multiplexed 4-digit display scanner with frame-synchronous data update and leading-zero blanking
//   clk, reset (async, active high), load/data (capture strobe + 4 nibbles), lz_en (leading-zero blanking)
//   bin (selected nibble), an (active-low digit enables), frame_start (pulse at each digit-0 slot)
module display_scan_ctrl #(
  parameter int PRESCALE = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] data,
  input  logic        lz_en,
  output logic [3:0]  bin,
  output logic [3:0]  an,
  output logic        frame_start
);
  localparam int PW = $clog2(PRESCALE);
  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   pending_q, pending_d, disp_q, disp_d;
  logic          pending_valid_q, pending_valid_d;
  logic          wrap_q, wrap_d;
  logic [3:0]    an_q, an_d, bin_q, bin_d;
  logic          frame_start_q, frame_start_d;
  logic          tick, boundary;
  logic [3:0]    blank, nib;
  always_comb begin
    tick            = presc_q == PW'(PRESCALE - 1);
    boundary        = tick && idx_q == 2'd3;
    presc_d         = tick ? '0 : presc_q + PW'(1);
    idx_d           = idx_q + {1'b0, tick};
    // a load coinciding with the boundary bypasses pending so it shows in the very next frame
    disp_d          = boundary ? (load ? data : pending_valid_q ? pending_q : disp_q) : disp_q;
    pending_d       = load ? data : pending_q;
    pending_valid_d = !boundary && (load || pending_valid_q);
    // a digit blanks only if it and every higher digit are zero; digit 0 always lights
    blank[3]        = lz_en && disp_q[15:12] == 4'h0;
    blank[2]        = blank[3] && disp_q[11:8] == 4'h0;
    blank[1]        = blank[2] && disp_q[7:4] == 4'h0;
    blank[0]        = 1'b0;
    nib             = disp_q[{idx_q, 2'b00} +: 4];
    an_d            = blank[idx_q] ? 4'hf : ~(4'b0001 << idx_q);
    bin_d           = blank[idx_q] ? 4'h0 : nib;
    // wrap_q marks the cycle the index returns to 0; the pulse lands with the registered an
    wrap_d          = boundary;
    frame_start_d   = wrap_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q         <= '0;
      idx_q           <= '0;
      pending_q       <= '0;
      pending_valid_q <= 1'b0;
      disp_q          <= '0;
      wrap_q          <= 1'b0;
      an_q            <= 4'hf;
      bin_q           <= 4'h0;
      frame_start_q   <= 1'b0;
    end else begin
      presc_q         <= presc_d;
      idx_q           <= idx_d;
      pending_q       <= pending_d;
      pending_valid_q <= pending_valid_d;
      disp_q          <= disp_d;
      wrap_q          <= wrap_d;
      an_q            <= an_d;
      bin_q           <= bin_d;
      frame_start_q   <= frame_start_d;
    end
  end
  assign an          = an_q;
  assign bin         = bin_q;
  assign frame_start = frame_start_q;
endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: directed self-checking bench for display_scan_ctrl with PRESCALE=4 (16-cycle frames)
module tb_display_scan_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [15:0] data = '0;
  logic        lz_en = 1'b0;
  logic [3:0]  bin, an;
  logic        frame_start;
  int tests = 0;
  int fails = 0;
  int edge_n = 0;

  display_scan_ctrl #(.PRESCALE(4)) dut (
    .clk(clk), .reset(reset), .load(load), .data(data), .lz_en(lz_en),
    .bin(bin), .an(an), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // edge_n counts rising edges since reset release; frame f shows digit j after edges 16f+4j+1..16f+4j+4
  task automatic step();
    @(posedge clk);
    edge_n++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if (an !== 4'hf || bin !== 4'h0 || frame_start !== 1'b0 || dut.pending_valid_q !== 1'b0) begin
      fails++;
      $display("FAIL reset_hold: an=%b bin=%h fs=%b pv=%b, expected an=1111 bin=0 fs=0 pv=0", an, bin, frame_start, dut.pending_valid_q);
    end
    reset = 1'b0;
    edge_n = 0;
    step();
    tests++;
    if (an !== 4'b1110 || bin !== 4'h0 || frame_start !== 1'b0) begin
      fails++;
      $display("FAIL reset_first_slot: an=%b bin=%h fs=%b, expected an=1110 bin=0 fs=0", an, bin, frame_start);
    end
  endtask

  task automatic test_basic();
    logic [15:0] v;
    logic [3:0] e_an, e_bin;
    logic e_fs;
    int j;
    data = 16'h1234;
    load = 1'b1;
    step();
    load = 1'b0;
    tests++;
    if (dut.pending_valid_q !== 1'b1 || an !== 4'b1110 || bin !== 4'h0) begin
      fails++;
      $display("FAIL basic_pending: pv=%b an=%b bin=%h, expected pv=1 an=1110 bin=0", dut.pending_valid_q, an, bin);
    end
    for (int k = 3; k <= 32; k++) begin
      step();
      v = edge_n <= 16 ? 16'h0000 : 16'h1234;
      j = ((edge_n - 1) % 16) / 4;
      e_an = ~(4'b0001 << j);
      e_bin = v[j*4 +: 4];
      e_fs = edge_n > 16 && edge_n % 16 == 1;
      tests++;
      if (an !== e_an || bin !== e_bin || frame_start !== e_fs) begin
        fails++;
        $display("FAIL basic edge %0d: an=%b bin=%h fs=%b, expected an=%b bin=%h fs=%b", edge_n, an, bin, frame_start, e_an, e_bin, e_fs);
      end
    end
  endtask

  task automatic test_midframe_load();
    logic [15:0] v;
    logic [3:0] e_an, e_bin;
    logic e_fs;
    int j;
    for (int k = 33; k <= 64; k++) begin
      step();
      v = edge_n <= 48 ? 16'h1234 : 16'hABCD;
      j = ((edge_n - 1) % 16) / 4;
      e_an = ~(4'b0001 << j);
      e_bin = v[j*4 +: 4];
      e_fs = edge_n % 16 == 1;
      tests++;
      if (an !== e_an || bin !== e_bin || frame_start !== e_fs) begin
        fails++;
        $display("FAIL midframe edge %0d: an=%b bin=%h fs=%b, expected an=%b bin=%h fs=%b", edge_n, an, bin, frame_start, e_an, e_bin, e_fs);
      end
      data = 16'hABCD;
      load = edge_n == 37;
    end
  endtask

  task automatic test_lz_blank();
    logic [15:0] v;
    logic [3:0] e_an, e_bin, blk;
    logic e_fs;
    int j;
    data = 16'h0050;
    load = 1'b1;
    lz_en = 1'b1;
    for (int k = 65; k <= 96; k++) begin
      step();
      load = 1'b0;
      v = edge_n <= 80 ? 16'hABCD : 16'h0050;
      blk = (edge_n > 80 && edge_n < 95) ? 4'b1100 : 4'b0000;
      j = ((edge_n - 1) % 16) / 4;
      e_an = blk[j] ? 4'hf : ~(4'b0001 << j);
      e_bin = blk[j] ? 4'h0 : v[j*4 +: 4];
      e_fs = edge_n % 16 == 1;
      tests++;
      if (an !== e_an || bin !== e_bin || frame_start !== e_fs) begin
        fails++;
        $display("FAIL lz edge %0d: an=%b bin=%h fs=%b, expected an=%b bin=%h fs=%b", edge_n, an, bin, frame_start, e_an, e_bin, e_fs);
      end
      if (edge_n == 94) lz_en = 1'b0;
    end
  endtask

  task automatic test_all_zero();
    logic [15:0] v;
    logic [3:0] e_an, e_bin, blk;
    logic e_fs;
    int j;
    data = 16'h0000;
    load = 1'b1;
    for (int k = 97; k <= 127; k++) begin
      step();
      load = 1'b0;
      v = edge_n <= 112 ? 16'h0050 : 16'h0000;
      blk = edge_n > 112 ? 4'b1110 : 4'b0000;
      j = ((edge_n - 1) % 16) / 4;
      e_an = blk[j] ? 4'hf : ~(4'b0001 << j);
      e_bin = blk[j] ? 4'h0 : v[j*4 +: 4];
      e_fs = edge_n % 16 == 1;
      tests++;
      if (an !== e_an || bin !== e_bin || frame_start !== e_fs) begin
        fails++;
        $display("FAIL zero edge %0d: an=%b bin=%h fs=%b, expected an=%b bin=%h fs=%b", edge_n, an, bin, frame_start, e_an, e_bin, e_fs);
      end
      if (edge_n == 112) lz_en = 1'b1;
    end
  endtask

  task automatic test_boundary_load();
    logic [3:0] e_an, e_bin;
    logic e_fs;
    int j;
    data = 16'h9876;
    load = 1'b1;
    step();
    load = 1'b0;
    tests++;
    if (dut.pending_valid_q !== 1'b0 || an !== 4'hf || bin !== 4'h0) begin
      fails++;
      $display("FAIL boundary_tick: pv=%b an=%b bin=%h, expected pv=0 an=1111 bin=0", dut.pending_valid_q, an, bin);
    end
    for (int k = 129; k <= 144; k++) begin
      step();
      j = ((edge_n - 1) % 16) / 4;
      e_an = ~(4'b0001 << j);
      e_bin = data[j*4 +: 4];
      e_fs = edge_n % 16 == 1;
      tests++;
      if (an !== e_an || bin !== e_bin || frame_start !== e_fs || dut.pending_valid_q !== 1'b0) begin
        fails++;
        $display("FAIL boundary edge %0d: an=%b bin=%h fs=%b pv=%b, expected an=%b bin=%h fs=%b pv=0", edge_n, an, bin, frame_start, dut.pending_valid_q, e_an, e_bin, e_fs);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] e_an;
    logic e_fs;
    int j;
    data = 16'h5555;
    load = 1'b1;
    step();
    load = 1'b0;
    tests++;
    if (dut.pending_valid_q !== 1'b1) begin
      fails++;
      $display("FAIL async_pending_set: pv=%b, expected 1", dut.pending_valid_q);
    end
    repeat (5) step();
    #2 reset = 1'b1;
    #1;
    tests++;
    if (an !== 4'hf || bin !== 4'h0 || frame_start !== 1'b0 || dut.pending_valid_q !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: an=%b bin=%h fs=%b pv=%b, expected an=1111 bin=0 fs=0 pv=0", an, bin, frame_start, dut.pending_valid_q);
    end
    lz_en = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    edge_n = 0;
    for (int k = 1; k <= 32; k++) begin
      step();
      j = ((edge_n - 1) % 16) / 4;
      e_an = ~(4'b0001 << j);
      e_fs = edge_n == 17;
      tests++;
      if (an !== e_an || bin !== 4'h0 || frame_start !== e_fs) begin
        fails++;
        $display("FAIL post_reset edge %0d: an=%b bin=%h fs=%b, expected an=%b bin=0 fs=%b", edge_n, an, bin, frame_start, e_an, e_fs);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_midframe_load();
    test_lz_blank();
    test_all_zero();
    test_boundary_load();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
